// File: rtl/aes_pkg.sv
// Shared AES helpers: state geometry, byte/state types and the InvShiftRows byte permutation.
package aes_pkg;
  localparam int NB      = 4;
  localparam int WORD    = 8;
  localparam int BLOCK_W = NB * NB * WORD;

  typedef logic [WORD-1:0]    byte_t;
  typedef logic [BLOCK_W-1:0] state_t;

  // Byte k lives at [BLOCK_W-1-WORD*k -: WORD] and is S[k%NB][k/NB]; out S'[r][c] = S[r][(c-r) mod NB].
  function automatic state_t inv_shift_rows(input state_t s);
    state_t res;
    byte_t  b;
    res = '0;
    for (int c = 0; c < NB; c++) begin
      for (int w = 0; w < NB; w++) begin
        b = s[BLOCK_W-1-WORD*(w+NB*((c-w+NB)%NB)) -: WORD];
        res[BLOCK_W-1-WORD*(NB*c+w) -: WORD] = b;
      end
    end
    return res;
  endfunction
endpackage

// File: rtl/inv_shiftrows_stage_if.sv
// Valid/ready block bus around the InvShiftRows stage; slave is the stage side, master the environment side.
interface inv_shiftrows_stage_if import aes_pkg::*; #(
  parameter int TAGW = 4
);
  logic            i_valid;
  logic            o_ready;
  state_t          i_block;
  logic [TAGW-1:0] i_tag;
  logic            o_valid;
  logic            i_ready;
  state_t          o_block;
  logic [TAGW-1:0] o_tag;

  modport slave (
    input  i_valid, i_block, i_tag, i_ready,
    output o_ready, o_valid, o_block, o_tag
  );

  modport master (
    output i_valid, i_block, i_tag, i_ready,
    input  o_ready, o_valid, o_block, o_tag
  );
endinterface

// File: rtl/aes_skid_buffer.sv
// Two-entry register slice (main + skid): 1-cycle latency into an empty main register.
// in_rdy comes straight from the skid flop, so upstream never sees a combinational path from out_rdy.
module aes_skid_buffer #(
  parameter int W = 132
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [W-1:0] in_dat,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_dat
);
  logic         m_valid_q, m_valid_d;
  logic [W-1:0] m_dat_q,   m_dat_d;
  logic         s_valid_q, s_valid_d;
  logic [W-1:0] s_dat_q,   s_dat_d;
  logic         accept;
  logic         drain;

  assign in_rdy  = ~s_valid_q;
  assign out_vld = m_valid_q;
  assign out_dat = m_dat_q;
  assign accept  = in_vld & ~s_valid_q;
  assign drain   = m_valid_q & out_rdy;

  always_comb begin
    m_valid_d = m_valid_q;
    m_dat_d   = m_dat_q;
    s_valid_d = s_valid_q;
    s_dat_d   = s_dat_q;
    // A full skid implies in_rdy=0, so the first branch never competes with an accept.
    if (drain && s_valid_q) begin
      m_dat_d   = s_dat_q;
      s_valid_d = 1'b0;
    end else if (accept && (!m_valid_q || drain)) begin
      m_dat_d   = in_dat;
      m_valid_d = 1'b1;
    end else if (accept && m_valid_q && !drain) begin
      s_dat_d   = in_dat;
      s_valid_d = 1'b1;
    end else if (drain) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      m_dat_q   <= '0;
      s_valid_q <= 1'b0;
      s_dat_q   <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_dat_q   <= m_dat_d;
      s_valid_q <= s_valid_d;
      s_dat_q   <= s_dat_d;
    end
  end
endmodule

// File: rtl/inv_shiftrows_stage.sv
// AES InvShiftRows pipeline stage: permutation is wiring, result and tag registered (1-cycle latency).
// Holds up to two blocks under backpressure; o_ready is a registered signal.
module inv_shiftrows_stage import aes_pkg::*; #(
  parameter int NB   = 4,
  parameter int WORD = 8,
  parameter int TAGW = 4
) (
  input logic                  i_clk,
  input logic                  i_rst,
  inv_shiftrows_stage_if.slave bus
);
  localparam int BW = NB * NB * WORD;

  logic [BW-1:0]      xform;
  logic [BW+TAGW-1:0] in_dat;
  logic [BW+TAGW-1:0] out_dat;

  assign xform  = inv_shift_rows(bus.i_block);
  assign in_dat = {xform, bus.i_tag};

  aes_skid_buffer #(
    .W (BW + TAGW)
  ) u_skid (
    .clk     (i_clk),
    .rst     (i_rst),
    .in_vld  (bus.i_valid),
    .in_rdy  (bus.o_ready),
    .in_dat  (in_dat),
    .out_vld (bus.o_valid),
    .out_rdy (bus.i_ready),
    .out_dat (out_dat)
  );

  assign bus.o_block = out_dat[BW+TAGW-1:TAGW];
  assign bus.o_tag   = out_dat[TAGW-1:0];
endmodule

// File: tb/tb_inv_shiftrows_stage.sv
// Directed bench for inv_shiftrows_stage with a queue-based reference model checked every cycle.
module tb_inv_shiftrows_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  inv_shiftrows_stage_if #(.TAGW(4)) bus ();

  inv_shiftrows_stage #(.NB(4), .WORD(8), .TAGW(4)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [127:0] blk;
    logic [3:0]   tag;
  } item_t;

  item_t q[$];

  // Reference: unpack into a row/column byte matrix, rotate each row r right by r, repack.
  function automatic logic [127:0] ref_isr(input logic [127:0] x);
    logic [7:0]   st [4][4];
    logic [127:0] y;
    for (int k = 0; k < 16; k++) st[k%4][k/4] = x[127-8*k -: 8];
    for (int k = 0; k < 16; k++) y[127-8*k -: 8] = st[k%4][((k/4)-(k%4)+4)%4];
    return y;
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Model: FIFO of depth 2; pop on valid&ready, push on valid when fewer than 2 held.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
    end else begin
      bit do_pop, do_push;
      item_t it;
      do_pop  = (q.size() > 0) && bus.i_ready;
      do_push = bus.i_valid && (q.size() < 2);
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        it.blk = ref_isr(bus.i_block);
        it.tag = bus.i_tag;
        q.push_back(it);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("model_o_ready", 128'(bus.o_ready), 128'(q.size() < 2));
      check("model_o_valid", 128'(bus.o_valid), 128'(q.size() > 0));
      if (q.size() > 0) begin
        check("model_o_block", bus.o_block, q[0].blk);
        check("model_o_tag", 128'(bus.o_tag), 128'(q[0].tag));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [127:0] b, input logic [3:0] t);
    bus.i_valid = v;
    bus.i_block = b;
    bus.i_tag   = t;
  endtask

  logic [127:0] blk_a, blk_b, blk_c, blk_h;
  logic [127:0] lit;

  initial begin
    drive(1'b0, 128'h0, 4'h0);
    bus.i_ready = 1'b0;
    #2;
    check("rst_o_valid", 128'(bus.o_valid), 128'd0);
    check("rst_o_ready", 128'(bus.o_ready), 128'd1);
    check("rst_o_block", bus.o_block, 128'd0);
    check("rst_o_tag", 128'(bus.o_tag), 128'd0);
    step();
    rst = 1'b0;
    step();

    // Basic transform
    bus.i_ready = 1'b1;
    drive(1'b1, 128'h000102030405060708090a0b0c0d0e0f, 4'd3);
    step();
    drive(1'b0, 128'h0, 4'h0);
    lit = 128'h000d0a0704010e0b0805020f0c090603;
    check("basic_o_valid", 128'(bus.o_valid), 128'd1);
    check("basic_o_block", bus.o_block, lit);
    check("basic_o_tag", 128'(bus.o_tag), 128'd3);
    step();

    // Round trip of forward ShiftRows
    drive(1'b1, 128'h00050a0f04090e03080d02070c01060b, 4'd9);
    step();
    drive(1'b0, 128'h0, 4'h0);
    lit = 128'h000102030405060708090a0b0c0d0e0f;
    check("roundtrip_o_block", bus.o_block, lit);
    check("roundtrip_o_tag", 128'(bus.o_tag), 128'd9);
    step();

    // Streaming, back-to-back (drain+accept each edge)
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, {$urandom, $urandom, $urandom, $urandom}, 4'(i));
      step();
      check("stream_o_valid", 128'(bus.o_valid), 128'd1);
      check("stream_o_tag", 128'(bus.o_tag), 128'(i));
      check("stream_o_ready", 128'(bus.o_ready), 128'd1);
    end
    drive(1'b0, 128'h0, 4'h0);
    step();
    check("stream_empty", 128'(bus.o_valid), 128'd0);

    // Backpressure: A held, B skidded, C stalled
    blk_a = 128'h11223344556677889900aabbccddeeff;
    blk_b = 128'hfedcba98765432100123456789abcdef;
    blk_c = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    bus.i_ready = 1'b0;
    drive(1'b1, blk_a, 4'd10);
    step();
    check("bp_a_ready", 128'(bus.o_ready), 128'd1);
    drive(1'b1, blk_b, 4'd11);
    step();
    check("bp_b_ready", 128'(bus.o_ready), 128'd0);
    check("bp_a_held", bus.o_block, ref_isr(blk_a));
    drive(1'b1, blk_c, 4'd12);
    step();
    check("bp_c_wait_ready", 128'(bus.o_ready), 128'd0);
    check("bp_a_still", 128'(bus.o_tag), 128'd10);
    bus.i_ready = 1'b1;
    step();
    check("bp_b_out", 128'(bus.o_tag), 128'd11);
    check("bp_b_blk", bus.o_block, ref_isr(blk_b));
    step();
    drive(1'b0, 128'h0, 4'h0);
    check("bp_c_out", 128'(bus.o_tag), 128'd12);
    check("bp_c_ready", 128'(bus.o_ready), 128'd1);
    step();
    check("bp_done", 128'(bus.o_valid), 128'd0);

    // Reset with both registers full
    bus.i_ready = 1'b0;
    drive(1'b1, blk_a, 4'd1);
    step();
    drive(1'b1, blk_b, 4'd2);
    step();
    drive(1'b0, 128'h0, 4'h0);
    check("prerst_full", 128'(bus.o_ready), 128'd0);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_o_valid", 128'(bus.o_valid), 128'd0);
    check("midrst_o_ready", 128'(bus.o_ready), 128'd1);
    check("midrst_o_block", bus.o_block, 128'd0);
    check("midrst_o_tag", 128'(bus.o_tag), 128'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    bus.i_ready = 1'b1;
    blk_h = 128'hdeadbeefcafef00d0123456789abcdef;
    drive(1'b1, blk_h, 4'd5);
    step();
    drive(1'b0, 128'h0, 4'h0);
    check("postrst_tag", 128'(bus.o_tag), 128'd5);
    check("postrst_blk", bus.o_block, ref_isr(blk_h));
    step();
    check("postrst_no_stale", 128'(bus.o_valid), 128'd0);
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
